// File: rtl/traffic_light_ctrl.sv
// Intersection controller: main road default green, N_SIDE round-robin side roads, one pedestrian crossing.
// Optional emergency preemption is compiled in when TL_PREEMPT_EN is defined.
module traffic_light_ctrl #(
  parameter int unsigned N_SIDE       = 2,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned T_MIN_GREEN  = 6,
  parameter int unsigned T_YELLOW     = 2,
  parameter int unsigned T_CLEAR      = 1,
  parameter int unsigned T_SIDE_GREEN = 4,
  parameter int unsigned T_WALK       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SIDE-1:0]     car,
  input  logic                  pedestrian,
  input  logic                  preempt,
  output logic [1:0]            main_light,
  output logic [2*N_SIDE-1:0]   side_light,
  output logic                  walk,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      counter
);

  localparam int unsigned IDX_W = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_GREEN  = 2'b10;

  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(T_SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(T_WALK - 1);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    CLEAR_IN    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    WALK        = 3'd5,
    CLEAR_OUT   = 3'd6,
    PREEMPT     = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_SIDE-1:0]     car_req_q, car_req_d;
  logic                  ped_req_q, ped_req_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [1:0]            main_light_q, main_light_d;
  logic [2*N_SIDE-1:0]   side_light_q, side_light_d;
  logic                  walk_q, walk_d;

  logic [N_SIDE-1:0]     car_in;
  logic [N_SIDE-1:0]     car_pend;
  logic                  ped_pend;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;

`ifndef TL_PREEMPT_EN
  logic unused_preempt;
  assign unused_preempt = preempt;
`endif

  // Next state, request latches, counter and lamp decode of the next state
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    car_in    = car;
    sel_found = 1'b0;
    sel_idx   = ptr_q;

    // A request for the phase currently being served is dropped
    if (state_q == SIDE_GREEN) car_in[ptr_q] = 1'b0;
    car_pend = car_req_q | car_in;
    ped_pend = ped_req_q | (pedestrian & (state_q != WALK));

    // First pending channel strictly after the pointer, wrapping
    for (int k = 1; k <= int'(N_SIDE); k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % int'(N_SIDE);
      if (!sel_found && car_pend[IDX_W'(idx)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(idx);
      end
    end

    case (state_q)
      MAIN_GREEN:  if (cnt_q == MG_LAST && ((|car_pend) || ped_pend)) state_d = MAIN_YELLOW;
      MAIN_YELLOW: if (cnt_q == Y_LAST) state_d = CLEAR_IN;
      CLEAR_IN: begin
        if (cnt_q == C_LAST) begin
          if (ped_pend) begin
            state_d = WALK;
          end else if (sel_found) begin
            state_d = SIDE_GREEN;
            ptr_d   = sel_idx;
          end else begin
            state_d = CLEAR_OUT;
          end
        end
      end
      SIDE_GREEN:  if (cnt_q == SG_LAST) state_d = SIDE_YELLOW;
      SIDE_YELLOW: if (cnt_q == Y_LAST) state_d = CLEAR_OUT;
      WALK:        if (cnt_q == W_LAST) state_d = CLEAR_OUT;
      CLEAR_OUT:   if (cnt_q == C_LAST) state_d = MAIN_GREEN;
      PREEMPT:     state_d = CLEAR_OUT;
      default:     state_d = MAIN_GREEN;
    endcase

`ifdef TL_PREEMPT_EN
    if (preempt) begin
      state_d = PREEMPT;
      ptr_d   = ptr_q;
    end
`endif

    car_req_d = car_pend;
    if (state_d == SIDE_GREEN && state_q != SIDE_GREEN) car_req_d[ptr_d] = 1'b0;
    ped_req_d = ped_pend & ~(state_d == WALK && state_q != WALK);

    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      case (state_q)
        MAIN_GREEN: cnt_d = (cnt_q == MG_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        PREEMPT:    cnt_d = '0;
        default:    cnt_d = cnt_q + CNT_W'(1);
      endcase
    end

    case (state_d)
      MAIN_GREEN:  main_light_d = LAMP_GREEN;
      MAIN_YELLOW: main_light_d = LAMP_YELLOW;
      default:     main_light_d = LAMP_RED;
    endcase
    side_light_d = '0;
    if (state_d == SIDE_GREEN)  side_light_d[{ptr_d, 1'b0} +: 2] = LAMP_GREEN;
    if (state_d == SIDE_YELLOW) side_light_d[{ptr_d, 1'b0} +: 2] = LAMP_YELLOW;
    walk_d = (state_d == WALK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MAIN_GREEN;
      cnt_q        <= '0;
      car_req_q    <= '0;
      ped_req_q    <= 1'b0;
      ptr_q        <= IDX_W'(N_SIDE - 1);
      main_light_q <= LAMP_GREEN;
      side_light_q <= '0;
      walk_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      car_req_q    <= car_req_d;
      ped_req_q    <= ped_req_d;
      ptr_q        <= ptr_d;
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
      walk_q       <= walk_d;
    end
  end

  assign main_light = main_light_q;
  assign side_light = side_light_q;
  assign walk       = walk_q;
  assign state      = state_q;
  assign counter    = cnt_q;

endmodule
